// File: rtl/decode_stage_ctrl_pkg.sv
// Shared decode constants, status codes, mul/div FSM states and the D/X control word.
package ctrl_pkg;

   // Primary opcodes, insn[31:27]
   localparam logic [4:0] OP_RTYPE = 5'b00000;
   localparam logic [4:0] OP_J     = 5'b00001;
   localparam logic [4:0] OP_BNE   = 5'b00010;
   localparam logic [4:0] OP_JAL   = 5'b00011;
   localparam logic [4:0] OP_JR    = 5'b00100;
   localparam logic [4:0] OP_ADDI  = 5'b00101;
   localparam logic [4:0] OP_BLT   = 5'b00110;
   localparam logic [4:0] OP_SW    = 5'b00111;
   localparam logic [4:0] OP_LW    = 5'b01000;
   localparam logic [4:0] OP_INC   = 5'b01001;
   localparam logic [4:0] OP_SETX  = 5'b10101;
   localparam logic [4:0] OP_BEX   = 5'b10110;

   // ALU function codes, insn[6:2] for R-type
   localparam logic [4:0] ALU_ADD  = 5'b00000;
   localparam logic [4:0] ALU_SUB  = 5'b00001;
   localparam logic [4:0] ALU_MUL  = 5'b00110;
   localparam logic [4:0] ALU_DIV  = 5'b00111;

   localparam int RSTATUS_DEF = 30;
   localparam int RA_DEF      = 31;

   // Values written to $rstatus when a mul/div ends abnormally
   localparam logic [1:0] ST_NONE = 2'd0;
   localparam logic [1:0] ST_MUL  = 2'd1;
   localparam logic [1:0] ST_DIV  = 2'd2;
   localparam logic [1:0] ST_WDOG = 2'd3;

   typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_WB} md_state_e;

   typedef struct packed {
      logic [4:0] alu_op;
      logic       imm_sel;
      logic       mem_wren;
      logic       mem_to_reg;
      logic       branch;
      logic       jump;
      logic       wren;
      logic       is_lw;
      logic       is_md;
      logic       is_div;
   } dx_ctrl_t;

endpackage

// File: rtl/decode_stage_ctrl_if.sv
// F/D, multdiv and D/X signals of the decode stage; master drives, slave is the controller.
interface decode_stage_ctrl_if #(
   parameter int INSN_W = 32,
   parameter int REG_W  = 5
);
   logic [INSN_W-1:0] fd_insn;
   logic              fd_valid;
   logic              flush;
   logic              md_ready;
   logic              md_exception;
   logic [REG_W-1:0]  read_reg_a;
   logic [REG_W-1:0]  read_reg_b;
   logic              stall_fd;
   logic              md_start;
   logic              md_is_div;
   logic              dx_valid;
   logic [4:0]        dx_alu_op;
   logic              dx_imm_sel;
   logic              dx_mem_wren;
   logic              dx_mem_to_reg;
   logic              dx_branch;
   logic              dx_jump;
   logic              dx_wren;
   logic [REG_W-1:0]  dx_write_reg;
   logic [1:0]        dx_status_val;

   modport master (
      output fd_insn, fd_valid, flush, md_ready, md_exception,
      input  read_reg_a, read_reg_b, stall_fd, md_start, md_is_div, dx_valid,
             dx_alu_op, dx_imm_sel, dx_mem_wren, dx_mem_to_reg, dx_branch,
             dx_jump, dx_wren, dx_write_reg, dx_status_val
   );

   modport slave (
      input  fd_insn, fd_valid, flush, md_ready, md_exception,
      output read_reg_a, read_reg_b, stall_fd, md_start, md_is_div, dx_valid,
             dx_alu_op, dx_imm_sel, dx_mem_wren, dx_mem_to_reg, dx_branch,
             dx_jump, dx_wren, dx_write_reg, dx_status_val
   );
endinterface

// File: rtl/decode_stage_ctrl_insn_decoder.sv
// Purely combinational field decode of one instruction into D/X control and regfile ports.
module insn_decoder
   import ctrl_pkg::*;
#(
   parameter int INSN_W  = 32,
   parameter int REG_W   = 5,
   parameter int MD_EN   = 1,
   parameter int RSTATUS = RSTATUS_DEF,
   parameter int RA      = RA_DEF
) (
   input  logic [INSN_W-1:0] insn,
   output dx_ctrl_t          ctrl,
   output logic [REG_W-1:0]  read_reg_a,
   output logic [REG_W-1:0]  read_reg_b,
   output logic [REG_W-1:0]  write_reg,
   output logic              use_a,
   output logic              use_b
);
   logic [4:0] opcode, fn, rd, rs, rt;
   logic is_r, is_md, md_nop, is_addi, is_sw, is_lw, is_j, is_bne, is_jal;
   logic is_jr, is_blt, is_setx, is_bex, is_inc;
   logic unused_bits;

   assign opcode  = insn[31:27];
   assign rd      = insn[26:22];
   assign rs      = insn[21:17];
   assign rt      = insn[16:12];
   assign fn      = insn[6:2];
   assign unused_bits = ^{insn[11:7], insn[1:0]};

   assign is_r    = (opcode == OP_RTYPE);
   assign is_md   = is_r && (fn == ALU_MUL || fn == ALU_DIV);
   // Without a multdiv unit these become architectural nops
   assign md_nop  = is_md && (MD_EN == 0);
   assign is_addi = (opcode == OP_ADDI);
   assign is_sw   = (opcode == OP_SW);
   assign is_lw   = (opcode == OP_LW);
   assign is_j    = (opcode == OP_J);
   assign is_bne  = (opcode == OP_BNE);
   assign is_jal  = (opcode == OP_JAL);
   assign is_jr   = (opcode == OP_JR);
   assign is_blt  = (opcode == OP_BLT);
   assign is_setx = (opcode == OP_SETX);
   assign is_bex  = (opcode == OP_BEX);
   assign is_inc  = (opcode == OP_INC);

   // Field decode; inc_score behaves exactly like addi
   always_comb begin
      ctrl  = '0;
      use_a = 1'b0;
      use_b = 1'b0;
      read_reg_a = is_bex ? REG_W'(RSTATUS) : REG_W'(rs);
      if (is_bex || is_addi || is_inc)
         read_reg_b = '0;
      else if (is_sw || is_bne || is_blt || is_jr)
         read_reg_b = REG_W'(rd);
      else
         read_reg_b = REG_W'(rt);
      write_reg = is_jal ? REG_W'(RA) : (is_setx ? REG_W'(RSTATUS) : REG_W'(rd));
      if (!md_nop) begin
         ctrl.alu_op     = is_r ? fn : ((is_bne || is_blt || is_bex) ? ALU_SUB : ALU_ADD);
         ctrl.imm_sel    = is_addi || is_sw || is_lw || is_inc;
         ctrl.mem_wren   = is_sw;
         ctrl.mem_to_reg = is_lw;
         ctrl.branch     = is_bne || is_blt || is_bex;
         ctrl.jump       = is_j || is_jal || is_jr;
         ctrl.wren       = (is_r || is_addi || is_lw || is_jal || is_setx || is_inc)
                           && (write_reg != '0);
         ctrl.is_lw      = is_lw;
         ctrl.is_md      = is_md;
         ctrl.is_div     = is_md && (fn == ALU_DIV);
         use_a           = is_r || is_addi || is_sw || is_lw || is_bne || is_blt
                           || is_inc || is_bex;
         use_b           = is_r || is_sw || is_bne || is_blt || is_jr;
      end
   end
endmodule

// File: rtl/decode_stage_ctrl.sv
// Decode/issue controller: D/X latch, load-use bubbles, flushes, mul/div sequencing and watchdog.
module decode_stage_ctrl
   import ctrl_pkg::*;
#(
   parameter int INSN_W     = 32,
   parameter int REG_W      = 5,
   parameter int MD_EN      = 1,
   parameter int MD_TIMEOUT = 64,
   parameter int RSTATUS    = RSTATUS_DEF,
   parameter int RA         = RA_DEF
) (
   input logic                clock,
   input logic                reset_n,
   decode_stage_ctrl_if.slave bus
);
   localparam int CNT_W = $clog2(MD_TIMEOUT + 1);

   md_state_e        state, state_nxt;
   logic [CNT_W-1:0] cnt;
   dx_ctrl_t         dec, dx;
   logic [REG_W-1:0] dec_wr_reg, dx_wr_reg, rra, rrb;
   logic             use_a, use_b, dx_vld, exc_q;
   logic [1:0]       status_q;
   logic             load_use, timeout, md_done, dx_load, dx_bubble, stall;

   insn_decoder #(
      .INSN_W(INSN_W), .REG_W(REG_W), .MD_EN(MD_EN), .RSTATUS(RSTATUS), .RA(RA)
   ) u_dec (
      .insn(bus.fd_insn), .ctrl(dec), .read_reg_a(rra), .read_reg_b(rrb),
      .write_reg(dec_wr_reg), .use_a(use_a), .use_b(use_b)
   );

   assign load_use = dx_vld && dx.is_lw && (dx_wr_reg != '0) && bus.fd_valid &&
                     ((use_a && rra == dx_wr_reg) || (use_b && rrb == dx_wr_reg));
   assign timeout  = (cnt == CNT_W'(MD_TIMEOUT - 1));
   assign md_done  = bus.md_ready || timeout;

   // Next state plus D/X load/bubble and stall decisions; flush only matters in IDLE
   always_comb begin
      state_nxt = state;
      dx_load   = 1'b0;
      dx_bubble = 1'b0;
      stall     = 1'b0;
      case (state)
         MD_IDLE: begin
            dx_load   = 1'b1;
            dx_bubble = bus.flush || load_use;
            stall     = load_use && !bus.flush;
            if (!dx_bubble && bus.fd_valid && dec.is_md) state_nxt = MD_BUSY;
         end
         MD_BUSY: begin
            stall = 1'b1;
            if (md_done) state_nxt = MD_WB;
         end
         MD_WB: begin
            dx_load   = 1'b1;
            state_nxt = (bus.fd_valid && dec.is_md) ? MD_BUSY : MD_IDLE;
         end
         default: state_nxt = MD_IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= MD_IDLE;
      else          state <= state_nxt;
   end

   // Watchdog: cleared on BUSY entry, counts BUSY cycles; leaving BUSY stops it before wrap
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)                                    cnt <= '0;
      else if (state != MD_BUSY && state_nxt == MD_BUSY) cnt <= '0;
      else if (state == MD_BUSY)                       cnt <= cnt + CNT_W'(1);
   end

   // D/X latch; exception redirect captured when BUSY completes, cleared on next load
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         dx_vld    <= 1'b0;
         dx        <= '0;
         dx_wr_reg <= '0;
         exc_q     <= 1'b0;
         status_q  <= ST_NONE;
      end else if (dx_load) begin
         dx_vld    <= bus.fd_valid && !dx_bubble;
         dx        <= (bus.fd_valid && !dx_bubble) ? dec : '0;
         dx_wr_reg <= (bus.fd_valid && !dx_bubble) ? dec_wr_reg : '0;
         exc_q     <= 1'b0;
         status_q  <= ST_NONE;
      end else if (state == MD_BUSY && md_done) begin
         exc_q    <= bus.md_ready ? bus.md_exception : 1'b1;
         status_q <= bus.md_ready ? (bus.md_exception ? (dx.is_div ? ST_DIV : ST_MUL) : ST_NONE)
                                  : ST_WDOG;
      end
   end

   assign bus.read_reg_a    = rra;
   assign bus.read_reg_b    = rrb;
   assign bus.stall_fd      = stall;
   assign bus.md_start      = (state == MD_BUSY) && (cnt == '0) && dx.is_md;
   assign bus.md_is_div     = dx.is_div;
   assign bus.dx_valid      = dx_vld;
   assign bus.dx_alu_op     = dx.alu_op;
   assign bus.dx_imm_sel    = dx.imm_sel;
   assign bus.dx_mem_wren   = dx.mem_wren;
   assign bus.dx_mem_to_reg = dx.mem_to_reg;
   assign bus.dx_branch     = dx.branch;
   assign bus.dx_jump       = dx.jump;
   assign bus.dx_wren       = (state == MD_BUSY) ? 1'b0 :
                              (state == MD_WB)   ? (dx.wren || exc_q) : dx.wren;
   assign bus.dx_write_reg  = exc_q ? REG_W'(RSTATUS) : dx_wr_reg;
   assign bus.dx_status_val = status_q;
endmodule

// File: tb/tb_decode_stage_ctrl.sv
// Directed bench: main controller (MD_TIMEOUT 64) and a second one with MD_TIMEOUT 8 for the watchdog.
module tb_decode_stage_ctrl;
   import ctrl_pkg::*;

   logic clock;
   logic reset_n;
   int   n_chk;
   int   n_err;
   int   starts, stalls, wrens;

   decode_stage_ctrl_if b ();
   decode_stage_ctrl_if w ();

   decode_stage_ctrl #(.MD_TIMEOUT(64)) dut (.clock(clock), .reset_n(reset_n), .bus(b));
   decode_stage_ctrl #(.MD_TIMEOUT(8))  dut_wd (.clock(clock), .reset_n(reset_n), .bus(w));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] fn);
      return {OP_RTYPE, rd, rs, rt, 5'd0, fn, 2'b00};
   endfunction

   function automatic logic [31:0] itype(input logic [4:0] op, input logic [4:0] rd,
                                         input logic [4:0] rs, input logic [16:0] imm);
      return {op, rd, rs, imm};
   endfunction

   initial begin
      n_chk = 0;
      n_err = 0;
      reset_n = 1'b0;
      b.fd_insn = rtype(3, 1, 2, ALU_ADD);
      b.fd_valid = 1'b0; b.flush = 1'b0; b.md_ready = 1'b0; b.md_exception = 1'b0;
      w.fd_insn = '0;
      w.fd_valid = 1'b0; w.flush = 1'b0; w.md_ready = 1'b0; w.md_exception = 1'b0;
      #3;
      check("rst_dx_valid", b.dx_valid, 0);
      check("rst_dx_wren", b.dx_wren, 0);
      check("rst_stall", b.stall_fd, 0);
      check("rst_md_start", b.md_start, 0);
      check("rst_wreg", b.dx_write_reg, 0);
      check("rst_rra", b.read_reg_a, 1);
      check("rst_rrb", b.read_reg_b, 2);
      tick(); tick();
      reset_n = 1'b1;

      // add $3,$1,$2
      b.fd_valid = 1'b1;
      tick();
      check("add_valid", b.dx_valid, 1);
      check("add_wren", b.dx_wren, 1);
      check("add_wreg", b.dx_write_reg, 3);
      check("add_aluop", b.dx_alu_op, 0);
      check("add_imm", b.dx_imm_sel, 0);

      // addi $7,$1,5
      b.fd_insn = itype(OP_ADDI, 7, 1, 5); #1;
      check("addi_rrb", b.read_reg_b, 0);
      tick();
      check("addi_imm", b.dx_imm_sel, 1);
      check("addi_wreg", b.dx_write_reg, 7);

      // sw $2,4($1)
      b.fd_insn = itype(OP_SW, 2, 1, 4); #1;
      check("sw_rrb", b.read_reg_b, 2);
      tick();
      check("sw_memwr", b.dx_mem_wren, 1);
      check("sw_wren", b.dx_wren, 0);

      // jal writes $ra
      b.fd_insn = itype(OP_JAL, 0, 0, 100);
      tick();
      check("jal_wreg", b.dx_write_reg, 31);
      check("jal_wren", b.dx_wren, 1);
      check("jal_jump", b.dx_jump, 1);

      // bex reads $rstatus
      b.fd_insn = itype(OP_BEX, 0, 0, 8); #1;
      check("bex_rra", b.read_reg_a, 30);
      tick();
      check("bex_aluop", b.dx_alu_op, 1);
      check("bex_branch", b.dx_branch, 1);

      // write to $0 is suppressed
      b.fd_insn = rtype(0, 1, 2, ALU_ADD);
      tick();
      check("r0_wren", b.dx_wren, 0);

      // lw $5,0($1) ; add $6,$5,$2
      b.fd_insn = itype(OP_LW, 5, 1, 0);
      tick();
      b.fd_insn = rtype(6, 5, 2, ALU_ADD); #1;
      check("lu_stall", b.stall_fd, 1);
      check("lu_rra", b.read_reg_a, 5);
      tick();
      check("lu_bubble", b.dx_valid, 0);
      check("lu_stall2", b.stall_fd, 0);
      tick();
      check("lu_issue_valid", b.dx_valid, 1);
      check("lu_issue_wreg", b.dx_write_reg, 6);

      // flush coincident with load-use
      b.fd_insn = itype(OP_LW, 5, 1, 0);
      tick();
      b.fd_insn = rtype(6, 5, 2, ALU_ADD);
      b.flush = 1'b1; #1;
      check("fl_stall", b.stall_fd, 0);
      tick();
      b.flush = 1'b0;
      check("fl_bubble", b.dx_valid, 0);
      b.fd_valid = 1'b0;
      tick();

      // mul $4,$1,$2, ready in the tenth busy cycle, mul $10 waiting behind it
      b.fd_valid = 1'b1;
      b.fd_insn = rtype(4, 1, 2, ALU_MUL);
      tick();
      b.fd_insn = rtype(10, 1, 2, ALU_MUL);
      starts = 0; stalls = 0; wrens = 0;
      for (int i = 1; i <= 10; i++) begin
         if (i == 10) b.md_ready = 1'b1;
         #1;
         starts += int'(b.md_start);
         stalls += int'(b.stall_fd);
         wrens  += int'(b.dx_wren);
         tick();
         b.md_ready = 1'b0;
      end
      check("mul_starts", starts, 1);
      check("mul_stalls", stalls, 10);
      check("mul_busy_wren", wrens, 0);
      check("mul_wb_wren", b.dx_wren, 1);
      check("mul_wb_wreg", b.dx_write_reg, 4);
      check("mul_wb_stall", b.stall_fd, 0);
      check("mul_wb_status", b.dx_status_val, 0);
      tick();
      check("b2b_start", b.md_start, 1);
      check("b2b_stall", b.stall_fd, 1);
      check("b2b_is_div", b.md_is_div, 0);
      b.fd_valid = 1'b0;
      tick();
      check("b2b_start_once", b.md_start, 0);
      b.md_ready = 1'b1;
      tick();
      b.md_ready = 1'b0;
      check("b2b_wreg", b.dx_write_reg, 10);
      check("b2b_wren", b.dx_wren, 1);
      tick();
      check("b2b_idle_valid", b.dx_valid, 0);

      // div $9,$1,$2 ending in a divide exception
      b.fd_valid = 1'b1;
      b.fd_insn = rtype(9, 1, 2, ALU_DIV);
      tick();
      check("div_start", b.md_start, 1);
      check("div_is_div", b.md_is_div, 1);
      b.fd_valid = 1'b0;
      tick(); tick();
      b.md_ready = 1'b1; b.md_exception = 1'b1;
      tick();
      b.md_ready = 1'b0; b.md_exception = 1'b0;
      check("div_wreg", b.dx_write_reg, 30);
      check("div_status", b.dx_status_val, 2);
      check("div_wren", b.dx_wren, 1);
      tick();
      check("div_after_wren", b.dx_wren, 0);
      check("div_after_status", b.dx_status_val, 0);

      // watchdog with MD_TIMEOUT = 8 and no ready
      w.fd_valid = 1'b1;
      w.fd_insn = rtype(4, 1, 2, ALU_MUL);
      tick();
      w.fd_valid = 1'b0;
      stalls = 0;
      for (int i = 0; i < 8; i++) begin
         #1;
         stalls += int'(w.stall_fd);
         tick();
      end
      check("wd_stalls", stalls, 8);
      check("wd_wreg", w.dx_write_reg, 30);
      check("wd_status", w.dx_status_val, 3);
      check("wd_wren", w.dx_wren, 1);
      check("wd_stall", w.stall_fd, 0);
      w.md_ready = 1'b1;
      tick();
      w.md_ready = 1'b0;
      check("wd_late_wren", w.dx_wren, 0);
      check("wd_late_start", w.md_start, 0);

      // reset in the middle of BUSY
      b.fd_valid = 1'b1;
      b.fd_insn = rtype(4, 1, 2, ALU_MUL);
      tick();
      b.fd_valid = 1'b0;
      tick();
      reset_n = 1'b0; #1;
      check("rb_valid", b.dx_valid, 0);
      check("rb_stall", b.stall_fd, 0);
      check("rb_start", b.md_start, 0);
      check("rb_wren", b.dx_wren, 0);
      tick();
      reset_n = 1'b1;
      starts = 0; wrens = 0;
      for (int i = 1; i <= 5; i++) begin
         if (i == 1) b.md_ready = 1'b1;
         #1;
         starts += int'(b.md_start);
         wrens  += int'(b.dx_wren);
         tick();
         b.md_ready = 1'b0;
      end
      check("rb_starts", starts, 0);
      check("rb_wrens", wrens, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/decode_stage_ctrl.md
# decode_stage_ctrl

Registered decode/issue controller for the 5-stage processor: decodes the F/D instruction, registers all datapath control into the D/X latch, and owns the pipeline-control decisions. It inserts load-use bubbles, sequences multi-cycle mul/div through a handshake with the multdiv unit, and applies branch flushes. It is parametrised in instruction/register widths and mul/div enable, and adds a watchdog that converts a hung multdiv into an exception write to $rstatus.

## Interface
- INSN_W, 32, instruction width
- REG_W, 5, register-address width
- MD_EN, 1, 1 = mul/div supported; 0 = mul/div decode as nop
- MD_TIMEOUT, 64, max BUSY cycles before watchdog fires (≥2)
- RSTATUS, 30, exception status register index; RA, 31, link register index
- clock  in  1  rising-edge clock (single clock domain)
- reset_n  in  1  asynchronous, active-low reset
- fd_insn  in  INSN_W  instruction in F/D latch
- fd_valid  in  1  F/D holds a real instruction
- flush  in  1  taken branch/jump resolved in X; kill next D/X entry
- md_ready  in  1  multdiv result valid (single-cycle pulse)
- md_exception  in  1  qualifies md_ready: overflow / divide-by-zero
- read_reg_a, read_reg_b  out  REG_W  combinational regfile read addresses for fd_insn
- stall_fd  out  1  hold PC and F/D latch this cycle
- md_start  out  1  one-cycle pulse launching multdiv; md_is_div  out  1  op select, valid with md_start
- dx_valid  out  1  D/X holds a real instruction
- dx_alu_op  out  5; dx_imm_sel, dx_mem_wren, dx_mem_to_reg, dx_branch, dx_jump  out  1 each
- dx_wren  out  1; dx_write_reg  out  REG_W  regfile write enable/address for the D/X instruction
- dx_status_val  out  2  value written to RSTATUS on exception (1 mul, 2 div, 3 watchdog)

## Operation
- Decode: opcode = insn[31:27]; R-type opcode 00000 with ALU op insn[6:2] (mul 00110, div 00111); addi 00101, sw 00111, lw 01000, j 00001, bne 00010, jal 00011, jr 00100, blt 00110, setx 10101, bex 10110, inc_score 01001 (treated as addi to rd with rs, imm). All-zero insn = nop (dx_wren 0).
- ALU op: R-type → insn[6:2]; bne/blt/bex → 00001; else 00000. dx_imm_sel = addi|sw|lw|inc_score.
- Read ports: A = bex ? RSTATUS : insn[21:17]; B = (bex|addi|inc_score) ? 0 : (sw|bne|blt|jr ? insn[26:22] : insn[16:12]).
- Write reg: jal → RA; setx → RSTATUS; else insn[26:22]. Writes to register 0 force dx_wren 0.
- Load-use: D/X holds valid lw with rd≠0 and fd_valid and fd_insn reads rd on an enabled port → stall_fd=1, D/X loads bubble (dx_valid=0) next edge. Exactly one bubble.
- Flush: flush=1 → D/X loads bubble; overrides load-use stall (stall_fd=0).
- Mul/div FSM states IDLE, BUSY, WB:
  - IDLE→BUSY when a valid mul/div is loaded into D/X; md_start pulses in the first BUSY cycle.
  - BUSY: stall_fd=1, D/X held, dx_wren=0; watchdog counter increments each cycle.
  - BUSY→WB on md_ready; md_exception=1 → dx_write_reg=RSTATUS, dx_status_val=1/2.
  - BUSY→WB on counter reaching MD_TIMEOUT without md_ready → RSTATUS, dx_status_val=3; later md_ready ignored.
  - WB: dx_wren=1 for one cycle, stall_fd=0, then IDLE; D/X loads the next instruction on the WB edge.
  - flush is ignored while BUSY/WB (mul/div is oldest in X).
- MD_EN=0: mul/div decode as nop, FSM stays IDLE.

## Timing
- Reset (async): FSM IDLE, counter 0, all dx_* outputs 0, dx_valid 0, md_start 0, stall_fd 0; read ports follow fd_insn.
- D/X latency one cycle; read_reg_a/b and stall_fd combinational from fd_insn and D/X state.
- md_start never pulses twice for one instruction; a back-to-back mul after WB starts BUSY the cycle after WB.
- reset_n low mid-BUSY aborts: IDLE, no write, no md_start after release until a new mul/div issues.
- Counter width $clog2(MD_TIMEOUT+1); cleared on entry to BUSY; never wraps.

## Structure
- Package ctrl_pkg: opcode and ALU-op constants, RSTATUS/RA defaults, status codes 1/2/3, FSM state enum, D/X control struct.
- Sub-module insn_decoder: purely combinational field decode of one instruction, instantiated once on fd_insn; FSM, hazard, watchdog and D/X register live in decode_stage_ctrl.

## Test plan
- add $3,$1,$2 (ALU op 00000) → next cycle dx_wren=1, dx_write_reg=3, dx_alu_op=00000, dx_valid=1.
- lw $5,0($1) then add $6,$5,$2 → stall_fd=1 one cycle, one bubble, add issues with read_reg_a=5.
- mul $4,$1,$2, md_ready after 10 cycles → md_start one pulse, stall_fd=1 ten cycles, WB dx_wren=1, dx_write_reg=4.
- div with md_exception=1 at ready → dx_write_reg=30, dx_status_val=2; MD_TIMEOUT=8 with no ready → status 3 after 8 BUSY cycles.
- flush coincident with load-use hazard → stall_fd=0, D/X bubble; reset_n low mid-BUSY → outputs 0, IDLE, no stray md_start.
